dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_pkg.sv | 35 +++
 rtl/dm_if.sv | 33 +++
 rtl/dm_bank.sv | 36 +++
 rtl/dm_responder.sv | 159 +++++++++++++++
 tb/tb_dm_responder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0
// ============================================================================
package dm_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dm_state_e;

  localparam int LANE_W           = 8;
  localparam int NUM_LANES        = 4;
  localparam int WORD_W           = LANE_W * NUM_LANES;
  localparam int DM_DEPTH_DEFAULT = 3072;
  localparam logic [31:0] DM_BASE_DEFAULT = 32'h0000_0000;

  // Replace the lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [WORD_W-1:0] merge_lanes(
    input logic [WORD_W-1:0]    old_w,
    input logic [WORD_W-1:0]    new_w,
    input logic [NUM_LANES-1:0] be
  );
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) r[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_if
// Brief    : CPU M-stage data port, status and write-trace bundle.
// Revision : 1.0
// ============================================================================
interface dm_if;
  import dm_pkg::*;

  logic [31:0]          m_data_addr;
  logic [WORD_W-1:0]    m_data_wdata;
  logic [NUM_LANES-1:0] m_data_byteen;
  logic [31:0]          m_inst_addr;
  logic [WORD_W-1:0]    m_data_rdata;
  logic                 ready;
  logic                 err;
  logic                 trace_valid;
  logic [31:0]          trace_pc;
  logic [31:0]          trace_addr;
  logic [WORD_W-1:0]    trace_data;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata, ready, err, trace_valid, trace_pc, trace_addr, trace_data
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata, ready, err, trace_valid, trace_pc, trace_addr, trace_data
  );

endinterface : dm_if
`default_nettype wire

// File: rtl/dm_bank.sv
`default_nettype none
// ============================================================================
// Module   : dm_bank
// Brief    : Word storage, one byte-enabled write port and one async read port.
// Revision : 1.0
// ============================================================================
module dm_bank
  import dm_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEFAULT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic                 clk,
  input  wire logic                 we,
  input  wire logic [NUM_LANES-1:0] be,
  input  wire logic [AW-1:0]        waddr,
  input  wire logic [WORD_W-1:0]    wdata,
  input  wire logic [AW-1:0]        raddr,
  output logic      [WORD_W-1:0]    rdata
);

  // Deliberately no reset: contents are only cleared by the owner's sweep.
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem_q[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule : dm_bank
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Brief    : Data-memory responder with clear-on-reset sweep, range check and
//            optional write trace (enabled by macro DM_TRACE_EN).
// Revision : 1.0
// ============================================================================
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH = DM_DEPTH_DEFAULT,
  parameter logic [31:0] BASE  = DM_BASE_DEFAULT
) (
  input wire logic clk,
  input wire logic reset,
  dm_if.slave      bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  dm_state_e         state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [31:0]       offset;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic              wr_req;
  logic              wr_acc;

  logic                 bank_we;
  logic [NUM_LANES-1:0] bank_be;
  logic [AW-1:0]        bank_waddr;
  logic [WORD_W-1:0]    bank_wdata;
  logic [WORD_W-1:0]    bank_rdata;

  assign offset   = bus.m_data_addr - BASE;
  assign in_range = (bus.m_data_addr >= BASE) && ({1'b0, offset} < SPAN);
  assign idx      = offset[AW+1:2];
  assign wr_req   = (state_q == ST_READY) && (bus.m_data_byteen != '0);
  assign wr_acc   = wr_req && in_range;

  // The bank write port is shared between the clearing sweep and CPU stores.
  always_comb begin
    bank_we    = 1'b0;
    bank_be    = '0;
    bank_waddr = idx;
    bank_wdata = bus.m_data_wdata;
    if (state_q == ST_INIT) begin
      bank_we    = 1'b1;
      bank_be    = '1;
      bank_waddr = cnt_q;
      bank_wdata = '0;
    end else if (wr_acc) begin
      bank_we    = 1'b1;
      bank_be    = bus.m_data_byteen;
    end
  end

  dm_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (bank_be),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (idx),
    .rdata (bank_rdata)
  );

  assign bus.m_data_rdata = ((state_q == ST_READY) && in_range) ? bank_rdata : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_READY);
    err_d   = wr_req && !in_range;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;

`ifdef DM_TRACE_EN
  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q, trace_pc_d;
  logic [31:0]       trace_addr_q, trace_addr_d;
  logic [WORD_W-1:0] trace_data_q, trace_data_d;

  // Record holds its last payload; only the valid flag pulses.
  always_comb begin
    trace_valid_d = wr_acc;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (wr_acc) begin
      trace_pc_d   = bus.m_inst_addr;
      trace_addr_d = {bus.m_data_addr[31:2], 2'b00};
      trace_data_d = merge_lanes(bank_rdata, bus.m_data_wdata, bus.m_data_byteen);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_pc    = trace_pc_q;
  assign bus.trace_addr  = trace_addr_q;
  assign bus.trace_data  = trace_data_q;
`else
  logic w_unused_trace;
  assign w_unused_trace  = ^bus.m_inst_addr;
  assign bus.trace_valid = 1'b0;
  assign bus.trace_pc    = '0;
  assign bus.trace_addr  = '0;
  assign bus.trace_data  = '0;
`endif

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Brief    : Directed self-checking bench for dm_responder (DEPTH=3072, BASE=0).
// Revision : 1.0
// ============================================================================
module tb_dm_responder;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc;

  dm_if bus ();

  dm_responder #(
    .DEPTH (3072),
    .BASE  (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_bus(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges from a reset release until ready; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 5000) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [31:0] exp_tv;
    logic [31:0] exp_td;
`ifdef DM_TRACE_EN
    exp_tv = 32'd1;
    exp_td = 32'h1234_AB78;
`else
    exp_tv = 32'd0;
    exp_td = 32'd0;
`endif
    set_bus(32'h0, 32'h0, 4'h0, 32'h0);
    reset = 1'b0;
    #3;
    check("reset_ready", {31'd0, bus.ready}, 32'd0);
    check("reset_err", {31'd0, bus.err}, 32'd0);
    check("reset_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    check("reset_trace_data", bus.trace_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_ready(cyc);
    check("init_cycles", cyc, 32'd3072);

    set_bus(32'h0000_2FFC, 32'h0, 4'h0, 32'h0);
    #1;
    check("rd_last_after_init", bus.m_data_rdata, 32'h0);

    // Full-word then single-lane write to 0x10, back to back.
    set_bus(32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0000_0100);
    step();
    check("trace_valid_w1", {31'd0, bus.trace_valid}, exp_tv);
    set_bus(32'h0000_0010, 32'h0000_AB00, 4'b0010, 32'h0000_0104);
    step();
    check("trace_valid_w2", {31'd0, bus.trace_valid}, exp_tv);
    check("trace_data_w2", bus.trace_data, exp_td);
`ifdef DM_TRACE_EN
    check("trace_pc_w2", bus.trace_pc, 32'h0000_0104);
    check("trace_addr_w2", bus.trace_addr, 32'h0000_0010);
`endif
    set_bus(32'h0000_0010, 32'h0, 4'h0, 32'h0);
    #1;
    check("rd_merged_0x10", bus.m_data_rdata, 32'h1234_AB78);
    step();
    check("trace_valid_idle", {31'd0, bus.trace_valid}, 32'd0);

    // Out-of-range store.
    set_bus(32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0108);
    step();
    check("oor_err", {31'd0, bus.err}, 32'd1);
    check("oor_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    set_bus(32'h0000_3000, 32'h0, 4'h0, 32'h0);
    #1;
    check("oor_rdata", bus.m_data_rdata, 32'h0);
    step();
    check("oor_err_one_cycle", {31'd0, bus.err}, 32'd0);

    // Out-of-range read alone must not raise err.
    set_bus(32'h0000_4000, 32'h0, 4'h0, 32'h0);
    step();
    check("oor_read_no_err", {31'd0, bus.err}, 32'd0);

    // Same-cycle read and write returns pre-edge contents.
    set_bus(32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0000_010C);
    #1;
    check("rw_same_pre", bus.m_data_rdata, 32'h0);
    step();
    set_bus(32'h0000_0020, 32'h0, 4'h0, 32'h0);
    #1;
    check("rw_same_post", bus.m_data_rdata, 32'hFFFF_FFFF);

    // Last in-range word with mixed lanes.
    set_bus(32'h0000_2FFC, 32'hCAFE_F00D, 4'b1001, 32'h0000_0110);
    step();
    check("last_word_err", {31'd0, bus.err}, 32'd0);
    set_bus(32'h0000_2FFE, 32'h0, 4'h0, 32'h0);
    #1;
    check("last_word_rd", bus.m_data_rdata, 32'hCA00_000D);

    // Reset again (READY -> INIT), memory content must be hidden.
    @(negedge clk);
    reset = 1'b0;
    set_bus(32'h0000_0010, 32'h0, 4'h0, 32'h0);
    #1;
    check("rst2_ready", {31'd0, bus.ready}, 32'd0);
    check("init_rdata_hidden", bus.m_data_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (1000) step();
    check("mid_init_ready", {31'd0, bus.ready}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_init_rst_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready(cyc);
    check("reinit_cycles", cyc, 32'd3072);
    set_bus(32'h0000_0010, 32'h0, 4'h0, 32'h0);
    #1;
    check("reinit_rd_0x10", bus.m_data_rdata, 32'h0);
    set_bus(32'h0000_0020, 32'h0, 4'h0, 32'h0);
    #1;
    check("reinit_rd_0x20", bus.m_data_rdata, 32'h0);
    set_bus(32'h0000_2FFC, 32'h0, 4'h0, 32'h0);
    #1;
    check("reinit_rd_last", bus.m_data_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dm_responder
`default_nettype wire
